// File: rtl/entity_motion_updater.sv
// entity_motion_updater
//   Once per divider tick (when start is high) walks entities 0..N_ENT-1,
//   applies each entity's turn/move command and resolves moves against an
//   external occupancy grid one axis at a time, so a blocked axis slides
//   along the wall while the free axis still advances.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   start               : level enable sampled on divider ticks
//   cmd                 : per entity {turn_right, turn_left, fwd, back}
//   cur_pos_x/y, cur_angle : current entity state, packed entity 0 lowest
//   dir_angle -> dir_x/y : external direction lookup (same-cycle answer)
//   grid_req/x/y, grid_ack, grid_out : occupancy lookup handshake
//   next_pos_x/y, next_angle : registered per-entity results
//   busy                : high while entities are being processed
//   done                : one-cycle pulse when the sequence finishes
module entity_motion_updater #(
  parameter int N_ENT       = 2,
  parameter int TURN_SPEED  = 10,
  parameter int DIV_BITS    = 20,
  parameter int CELL_SHIFT  = 12,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*N_ENT-1:0]    cmd,
  input  logic [18*N_ENT-1:0]   cur_pos_x,
  input  logic [17*N_ENT-1:0]   cur_pos_y,
  input  logic [8*N_ENT-1:0]    cur_angle,
  output logic [7:0]            dir_angle,
  input  logic [17:0]           dir_x,
  input  logic [16:0]           dir_y,
  output logic                  grid_req,
  output logic [5:0]            grid_x,
  output logic [4:0]            grid_y,
  input  logic                  grid_ack,
  input  logic [2:0]            grid_out,
  output logic [18*N_ENT-1:0]   next_pos_x,
  output logic [17*N_ENT-1:0]   next_pos_y,
  output logic [8*N_ENT-1:0]    next_angle,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ENT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [7:0]       TURN_STEP = 8'(TURN_SPEED);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CHECK_X = 3'd2,
    S_CHECK_Y = 3'd3,
    S_COMMIT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic [DIV_BITS-1:0]  div_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 load_ph_r;   // second LOAD cycle: dir_x/dir_y now valid
  logic [3:0]           cmd_r;
  logic [17:0]          pos_x_r, cand_x_r;
  logic [16:0]          pos_y_r, cand_y_r;
  logic [7:0]           ang_r, dir_angle_r;
  logic [TMO_W-1:0]     tmo_r;
  logic                 grid_req_r;
  logic [5:0]           grid_x_r;
  logic [4:0]           grid_y_r;
  logic [18*N_ENT-1:0]  next_pos_x_r;
  logic [17*N_ENT-1:0]  next_pos_y_r;
  logic [8*N_ENT-1:0]   next_angle_r;
  logic                 busy_r, done_r;

  logic        tick_s, is_right_s, is_left_s, is_fwd_s, is_back_s, is_move_s;
  logic        tmo_hit_s, resp_s, cell_free_s;
  logic [17:0] step_x_s, res_x_s;
  logic [16:0] step_y_s;

  function automatic logic [5:0] cell_x(input logic [17:0] p);
    return 6'(p >> CELL_SHIFT);
  endfunction

  function automatic logic [4:0] cell_y(input logic [16:0] p);
    return 5'(p >> CELL_SHIFT);
  endfunction

  // Only exact one-hot commands act; anything else holds the entity.
  assign is_right_s = (cmd_r == 4'b1000);
  assign is_left_s  = (cmd_r == 4'b0100);
  assign is_fwd_s   = (cmd_r == 4'b0010);
  assign is_back_s  = (cmd_r == 4'b0001);
  assign is_move_s  = is_fwd_s | is_back_s;

  assign tick_s      = (div_r == {DIV_BITS{1'b0}});
  // Unsigned add/sub of the two's-complement step wraps the coordinate.
  assign step_x_s    = is_back_s ? (pos_x_r - dir_x) : (pos_x_r + dir_x);
  assign step_y_s    = is_back_s ? (pos_y_r - dir_y) : (pos_y_r + dir_y);
  // An ack wins over a timeout landing on the same cycle.
  assign tmo_hit_s   = (tmo_r == TMO_LAST);
  assign resp_s      = grid_ack | tmo_hit_s;
  assign cell_free_s = grid_ack & (grid_out == 3'd0);
  assign res_x_s     = cell_free_s ? cand_x_r : pos_x_r;

  assign dir_angle  = dir_angle_r;
  assign grid_req   = grid_req_r;
  assign grid_x     = grid_x_r;
  assign grid_y     = grid_y_r;
  assign next_pos_x = next_pos_x_r;
  assign next_pos_y = next_pos_y_r;
  assign next_angle = next_angle_r;
  assign busy       = busy_r;
  assign done       = done_r;

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Sequencer next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start && tick_s) state_s = S_LOAD;
        else                 state_s = S_IDLE;
      end
      S_LOAD: begin
        if (!load_ph_r)     state_s = S_LOAD;
        else if (is_move_s) state_s = S_CHECK_X;
        else                state_s = S_COMMIT;
      end
      S_CHECK_X: begin
        if (resp_s) state_s = S_CHECK_Y;
        else        state_s = S_CHECK_X;
      end
      S_CHECK_Y: begin
        if (resp_s) state_s = S_COMMIT;
        else        state_s = S_CHECK_Y;
      end
      S_COMMIT: begin
        if (idx_r == LAST_IDX) state_s = S_DONE;
        else                   state_s = S_LOAD;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Divider, per-entity datapath, grid handshake and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_r        <= {DIV_BITS{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      load_ph_r    <= 1'b0;
      cmd_r        <= 4'd0;
      pos_x_r      <= 18'd0;
      pos_y_r      <= 17'd0;
      cand_x_r     <= 18'd0;
      cand_y_r     <= 17'd0;
      ang_r        <= 8'd0;
      dir_angle_r  <= 8'd0;
      tmo_r        <= {TMO_W{1'b0}};
      grid_req_r   <= 1'b0;
      grid_x_r     <= 6'd0;
      grid_y_r     <= 5'd0;
      next_pos_x_r <= {(18*N_ENT){1'b0}};
      next_pos_y_r <= {(17*N_ENT){1'b0}};
      next_angle_r <= {(8*N_ENT){1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      div_r  <= div_r + DIV_BITS'(1'b1);
      busy_r <= (state_s == S_LOAD) || (state_s == S_CHECK_X) ||
                (state_s == S_CHECK_Y) || (state_s == S_COMMIT);
      done_r <= (state_s == S_DONE);
      case (state_r)
        S_LOAD: begin
          if (!load_ph_r) begin
            // First cycle: capture the entity and present its angle to the lookup.
            load_ph_r   <= 1'b1;
            cmd_r       <= cmd[int'(idx_r)*4 +: 4];
            pos_x_r     <= cur_pos_x[int'(idx_r)*18 +: 18];
            pos_y_r     <= cur_pos_y[int'(idx_r)*17 +: 17];
            ang_r       <= cur_angle[int'(idx_r)*8 +: 8];
            dir_angle_r <= cur_angle[int'(idx_r)*8 +: 8];
          end else begin
            // Second cycle: direction step is valid, form candidates.
            load_ph_r <= 1'b0;
            cand_x_r  <= step_x_s;
            cand_y_r  <= step_y_s;
            tmo_r     <= {TMO_W{1'b0}};
            if (is_right_s)     ang_r <= ang_r + TURN_STEP;
            else if (is_left_s) ang_r <= ang_r - TURN_STEP;
            else                ang_r <= ang_r;
            if (is_move_s) begin
              grid_req_r <= 1'b1;
              grid_x_r   <= cell_x(step_x_s);
              grid_y_r   <= cell_y(pos_y_r);
            end
          end
        end
        S_CHECK_X: begin
          if (resp_s) begin
            // Request stays up; the Y query is issued at the resolved x.
            pos_x_r  <= res_x_s;
            grid_x_r <= cell_x(res_x_s);
            grid_y_r <= cell_y(cand_y_r);
            tmo_r    <= {TMO_W{1'b0}};
          end else begin
            tmo_r <= tmo_r + TMO_W'(1'b1);
          end
        end
        S_CHECK_Y: begin
          if (resp_s) begin
            if (cell_free_s) pos_y_r <= cand_y_r;
            grid_req_r <= 1'b0;
            tmo_r      <= {TMO_W{1'b0}};
          end else begin
            tmo_r <= tmo_r + TMO_W'(1'b1);
          end
        end
        S_COMMIT: begin
          next_pos_x_r[int'(idx_r)*18 +: 18] <= pos_x_r;
          next_pos_y_r[int'(idx_r)*17 +: 17] <= pos_y_r;
          next_angle_r[int'(idx_r)*8 +: 8]   <= ang_r;
          idx_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1'b1));
        end
        default: ;
      endcase
    end
  end

endmodule
